// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_master command port between NREQ clients,
// with per-owner response routing and a per-transaction watchdog.
module i2c_bus_arbiter #(
  parameter int NREQ        = 3,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [2*NREQ-1:0]   req_cmd,
  input  logic [7*NREQ-1:0]   req_slave,
  input  logic [8*NREQ-1:0]   req_reg,
  input  logic [8*NREQ-1:0]   req_wdata,
  input  logic [8*NREQ-1:0]   req_rdnum,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     grant,
  output logic [7:0]          rsp_rd_data,
  output logic [NREQ-1:0]     rsp_rd_valid,
  output logic [NREQ-1:0]     rsp_done,
  output logic [NREQ-1:0]     rsp_err,
  output logic                timeout,
  output logic                m_start,
  output logic [1:0]          m_cmd,
  output logic [6:0]          m_slave,
  output logic [7:0]          m_reg,
  output logic [7:0]          m_wdata,
  output logic [7:0]          m_rdnum,
  input  logic [7:0]          m_rd_data,
  input  logic                m_rd_valid,
  input  logic                m_busy,
  input  logic                m_done,
  input  logic                m_ack_err
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, RELEASE} state_t;

  state_t            state_q;
  logic [IDXW-1:0]   last_q;
  logic [WDW-1:0]    wdog_q;
  logic [NREQ-1:0]   req_ready_q, grant_q, rsp_rd_valid_q, rsp_done_q, rsp_err_q;
  logic [7:0]        rsp_rd_data_q;
  logic              timeout_q, m_start_q;
  logic [1:0]        m_cmd_q;
  logic [6:0]        m_slave_q;
  logic [7:0]        m_reg_q, m_wdata_q, m_rdnum_q;

  logic              arb_found_s;
  logic [IDXW-1:0]   arb_idx_s;
  logic [IDXW:0]     cand_s;
  logic [NREQ-1:0]   arb_onehot_s;
  logic [1:0]        sel_cmd_s;
  logic [6:0]        sel_slave_s;
  logic [7:0]        sel_reg_s, sel_wdata_s, sel_rdnum_s;

  // Round-robin search: first valid requester after the last owner, wrapping modulo NREQ.
  always_comb begin
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    cand_s      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = {1'b0, last_q} + (IDXW+1)'(k);
      if (cand_s >= (IDXW+1)'(NREQ)) begin
        cand_s = cand_s - (IDXW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!arb_found_s && req_valid[cand_s[IDXW-1:0]]) begin
        arb_found_s = 1'b1;
        arb_idx_s   = cand_s[IDXW-1:0];
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Command-field mux and one-hot grant for the arbitration winner.
  always_comb begin
    sel_cmd_s    = 2'b00;
    sel_slave_s  = 7'h00;
    sel_reg_s    = 8'h00;
    sel_wdata_s  = 8'h00;
    sel_rdnum_s  = 8'h00;
    arb_onehot_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx_s == IDXW'(i)) begin
        sel_cmd_s       = req_cmd[2*i +: 2];
        sel_slave_s     = req_slave[7*i +: 7];
        sel_reg_s       = req_reg[8*i +: 8];
        sel_wdata_s     = req_wdata[8*i +: 8];
        sel_rdnum_s     = req_rdnum[8*i +: 8];
        arb_onehot_s[i] = 1'b1;
      end else begin
        arb_onehot_s[i] = 1'b0;
      end
    end
  end

  // Arbiter FSM with registered outputs; response pulses default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_q         <= IDXW'(NREQ-1);
      wdog_q         <= '0;
      req_ready_q    <= '0;
      grant_q        <= '0;
      rsp_rd_valid_q <= '0;
      rsp_done_q     <= '0;
      rsp_err_q      <= '0;
      rsp_rd_data_q  <= 8'h00;
      timeout_q      <= 1'b0;
      m_start_q      <= 1'b0;
      m_cmd_q        <= 2'b00;
      m_slave_q      <= 7'h00;
      m_reg_q        <= 8'h00;
      m_wdata_q      <= 8'h00;
      m_rdnum_q      <= 8'h00;
    end else begin
      req_ready_q    <= '0;
      m_start_q      <= 1'b0;
      rsp_rd_valid_q <= '0;
      rsp_done_q     <= '0;
      rsp_err_q      <= '0;
      case (state_q)
        IDLE: begin
          if (arb_found_s && !m_busy) begin
            m_cmd_q     <= sel_cmd_s;
            m_slave_q   <= sel_slave_s;
            m_reg_q     <= sel_reg_s;
            m_wdata_q   <= sel_wdata_s;
            m_rdnum_q   <= sel_rdnum_s;
            grant_q     <= arb_onehot_s;
            req_ready_q <= arb_onehot_s;
            m_start_q   <= 1'b1;
            last_q      <= arb_idx_s;
            wdog_q      <= '0;
            state_q     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (m_rd_valid) begin
            rsp_rd_data_q  <= m_rd_data;
            rsp_rd_valid_q <= grant_q;
          end
          // A real completion wins over a watchdog expiry on the same cycle.
          if (m_done || m_ack_err) begin
            rsp_done_q <= grant_q;
            rsp_err_q  <= m_ack_err ? grant_q : '0;
            grant_q    <= '0;
            state_q    <= RELEASE;
          end else if (wdog_q == WDW'(TIMEOUT_CYC-1)) begin
            rsp_done_q <= grant_q;
            rsp_err_q  <= grant_q;
            timeout_q  <= 1'b1;
            grant_q    <= '0;
            state_q    <= RELEASE;
          end else begin
            wdog_q <= wdog_q + WDW'(1);
            if (state_q == WAIT_BUSY && m_busy) begin
              state_q <= WAIT_DONE;
            end
          end
        end
        RELEASE: begin
          if (!m_busy) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign grant        = grant_q;
  assign rsp_rd_data  = rsp_rd_data_q;
  assign rsp_rd_valid = rsp_rd_valid_q;
  assign rsp_done     = rsp_done_q;
  assign rsp_err      = rsp_err_q;
  assign timeout      = timeout_q;
  assign m_start      = m_start_q;
  assign m_cmd        = m_cmd_q;
  assign m_slave      = m_slave_q;
  assign m_reg        = m_reg_q;
  assign m_wdata      = m_wdata_q;
  assign m_rdnum      = m_rdnum_q;

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Round-robin arbiter that shares the single `i2c_master` command port between several on-board I2C clients, for example the MAX30102 sensor driver, a die-temperature poller and a display or EEPROM configurator. It accepts a complete command from one requester and launches it on the master. It routes read bytes and completion or error status back to the owning requester only, and releases the bus once the master is idle. A watchdog guarantees that a hung transaction cannot lock out the other clients.

## Interface
Parameters:
- `NREQ`, 3, number of requesters (2..8)
- `TIMEOUT_CYC`, 5_000_000, per-transaction watchdog in clk cycles (100 ms at 50 MHz)

Ports:
- `clk`  in  1  system clock, 50 MHz
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  request i; held high with fields stable until `req_ready[i]`
- `req_cmd`  in  2*NREQ  per-requester command; 00 = write, 01 = read; slice i is `[2i+1:2i]`
- `req_slave`  in  7*NREQ  7-bit slave address per requester
- `req_reg`  in  8*NREQ  register address per requester
- `req_wdata`  in  8*NREQ  write byte per requester
- `req_rdnum`  in  8*NREQ  read count per requester
- `req_ready`  out  NREQ  one-cycle accept pulse to the winner
- `grant`  out  NREQ  one-hot current owner; 0 when the bus is free
- `rsp_rd_data`  out  8  last read byte, broadcast to all requesters
- `rsp_rd_valid`  out  NREQ  read-byte strobe, owner bit only
- `rsp_done`  out  NREQ  transaction-complete pulse, owner bit only
- `rsp_err`  out  NREQ  NACK or timeout pulse, coincident with `rsp_done`
- `timeout`  out  1  sticky watchdog-fired flag; cleared only by reset
- `m_start`, `m_cmd[1:0]`, `m_slave[6:0]`, `m_reg[7:0]`, `m_wdata[7:0]`, `m_rdnum[7:0]`  out  command to `i2c_master`
- `m_rd_data[7:0]`, `m_rd_valid`, `m_busy`, `m_done`, `m_ack_err`  in  status from `i2c_master`

## Operation
- Every output is registered. Reset values: all outputs 0. Internal state: state = IDLE, round-robin pointer `last` = NREQ-1, watchdog = 0.
- IDLE:
  - Arbitrate when `req_valid` != 0 and `m_busy` = 0.
  - Search order is `last`+1, `last`+2, … modulo NREQ; the winner is w.
  - On arbitration: latch w's fields into `m_*`, set `grant` = 1<<w, pulse `req_ready[w]` and `m_start` for one cycle, set `last` = w, clear the watchdog, go to WAIT_BUSY.
- WAIT_BUSY:
  - `m_busy` = 1 → go to WAIT_DONE.
  - `m_done` or `m_ack_err` seen here is handled exactly as in WAIT_DONE; covers a fast master.
- WAIT_DONE:
  - Each `m_rd_valid` → `rsp_rd_data` = `m_rd_data` and `rsp_rd_valid[w]` pulses for one cycle.
  - `m_done` or `m_ack_err` → pulse `rsp_done[w]`. Also pulse `rsp_err[w]` if `m_ack_err` = 1. A simultaneous done and ack_err gives a single completion with the error bit set. Then go to RELEASE.
- Watchdog:
  - Counts every cycle in WAIT_BUSY and WAIT_DONE.
  - At `TIMEOUT_CYC`-1: pulse `rsp_done[w]` and `rsp_err[w]`, set `timeout` = 1, go to RELEASE.
- RELEASE: `grant` = 0, `m_*` fields hold their values. Go to IDLE the first cycle `m_busy` = 0; this guarantees at least one idle cycle between owners.
- Request rules:
  - A requester that drops `req_valid` before acceptance withdraws; this has no side effects.
  - `req_valid` held high after `req_ready` is a new request. It competes at the next IDLE, with the lowest priority.
  - Only the owner's response bits ever go high; non-owners see all-zero response bits.
- `m_*` fields remain stable from `m_start` until the next grant.
- Asynchronous reset mid-transaction returns everything to reset values on the same edge. No response pulses are issued for the aborted request.

## Timing
- `req_valid` sampled high in IDLE at edge t → `req_ready`, `grant`, `m_start` and fields valid at t+1.
- Minimum request-to-start latency is 1 cycle.
- `m_rd_valid` at t → `rsp_rd_valid[w]` at t+1; `m_done`/`m_ack_err` at t → `rsp_done`/`rsp_err` at t+1.
- Back-to-back transactions: the next `m_start` comes no earlier than 2 cycles after `rsp_done`, and only once `m_busy` = 0.
- Throughput is limited by the I2C master; arbitration overhead is ≤ 3 cycles per transaction.

## Test plan
- Single write, requester 1: slave 0x57, reg 0x09, data 0x40 → `req_ready[1]` and `m_start` with exactly those fields 1 cycle later. After the master's `m_done`, `rsp_done` = 3'b010 for one cycle; `grant` returns to 0.
- Requesters 0, 1 and 2 held high together after reset → grants in order 0, 1, 2. With all three re-asserted, the next round is again 0, 1, 2. No owner is served twice in a row while others are waiting.
- Requester 2 reads with `rdnum` = 6, master model returns 0x01..0x06 → six `rsp_rd_valid` = 3'b100 pulses carrying 0x01..0x06 in order. Requesters 0 and 1 see no strobes.
- Master model NACKs, asserting `m_ack_err` together with `m_done` → exactly one `rsp_done` and one `rsp_err` to the owner. A pending request from another requester is accepted after `m_busy` falls.
- `TIMEOUT_CYC` = 100 and the master never asserts `m_done` → `rsp_done` and `rsp_err` are pulsed 100 cycles after `m_start` and `timeout` = 1 sticks. The next request is accepted once `m_busy` = 0.
- `rst_n` pulsed low during WAIT_DONE of requester 1 → all outputs are 0 immediately. After release, simultaneous requests 1 and 0 grant requester 0 first.
